// File: rtl/al_accel_wreg_bank.sv
// Weight register bank: loads ROWS rows of K weights and presents the whole kernel on wreg_do.
// AL_ACCEL_WREG_DBUF_EN selects the double-buffered (shadow + active bank, swap commit) build.
module al_accel_wreg_bank #(
    parameter int DW   = 8,
    parameter int K    = 3,
    parameter int ROWS = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enb,
    input  logic                   wreg_valid,
    output logic                   wreg_ready,
    input  logic [K*DW-1:0]        wreg_di,
    input  logic                   swap,
    output logic [ROWS*K*DW-1:0]   wreg_do,
    output logic                   full,
    output logic                   wreg_vld
);
    localparam int RW = K * DW;
    localparam int BW = ROWS * RW;
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {EMPTY, LOAD, FULL} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_cnt_q, row_cnt_d;
    logic            full_q, full_d;
    logic            vld_q, vld_d;
    logic [BW-1:0]   load_q, load_d;
    logic            accept;
    logic            last_row;

    // resetn is folded in so the handshake is closed during reset regardless of enb
    assign wreg_ready = resetn & enb & (state_q != FULL);
    assign accept     = wreg_valid & wreg_ready;
    assign last_row   = (row_cnt_q == CW'(ROWS - 1));

`ifdef AL_ACCEL_WREG_DBUF_EN
    logic [BW-1:0]   active_q, active_d;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        full_d    = full_q;
        vld_d     = vld_q;
        load_d    = load_q;
        active_d  = active_q;
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_cnt_q == CW'(r)) load_d[r*RW +: RW] = wreg_di;
            end
            if (last_row) begin
                row_cnt_d = '0;
                state_d   = FULL;
                full_d    = 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
                state_d   = LOAD;
            end
        end
        if (enb && swap && (state_q == FULL)) begin
            active_d = load_q;
            state_d  = EMPTY;
            full_d   = 1'b0;
            vld_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) active_q <= '0;
        else         active_q <= active_d;
    end

    assign wreg_do = active_q;
`else
    logic unused_swap;
    assign unused_swap = swap;

    // Single bank: the kernel completes on the last row and the FSM never parks in FULL
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        full_d    = full_q;
        vld_d     = vld_q;
        load_d    = load_q;
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_cnt_q == CW'(r)) load_d[r*RW +: RW] = wreg_di;
            end
            if (row_cnt_q == '0) vld_d = 1'b0;
            if (last_row) begin
                row_cnt_d = '0;
                state_d   = EMPTY;
                vld_d     = 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
                state_d   = LOAD;
            end
        end
    end

    assign wreg_do = load_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= EMPTY;
            row_cnt_q <= '0;
            full_q    <= 1'b0;
            vld_q     <= 1'b0;
            load_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            full_q    <= full_d;
            vld_q     <= vld_d;
            load_q    <= load_d;
        end
    end

    assign full     = full_q;
    assign wreg_vld = vld_q;
endmodule
